// File: rtl/burst_ram_responder_if.sv
// Burst RAM command/response bundle.
// master: the requester driving commands; slave: the RAM responder.
interface burst_ram_responder_if #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64
);
  logic                         br_cmd;
  logic                         br_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]    br_addr;
  logic [DATA_BITWIDTH-1:0]     br_wr_data;
  logic [DATA_BITWIDTH/8-1:0]   br_data_mask;
  logic [DATA_BITWIDTH-1:0]     br_rd_data;
  logic                         br_rd_data_valid;
  logic                         br_busy;

  modport master (
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy
  );

  modport slave (
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy
  );
endinterface

// File: rtl/burst_ram_responder.sv
// Burst RAM responder: fixed-length read/write bursts into a small byte-maskable RAM.
// Reads return the first word READ_LATENCY cycles after accept; writes take one beat per
// cycle starting in the accept cycle. Addresses wrap within the RAM.
// Optional macro BURST_RAM_RESPONDER_INIT_DELAY_EN adds an INIT_CYCLES busy period after
// reset release.
module burst_ram_responder #(
  parameter int unsigned DEPTH_BITWIDTH = 4,
  parameter int unsigned DATA_BITWIDTH  = 64,
  parameter int unsigned BURST_COUNT    = 4,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned INIT_CYCLES    = 8
) (
  input logic                  clk,
  input logic                  rst,
  burst_ram_responder_if.slave br
);
  localparam int unsigned Words  = 2 ** DEPTH_BITWIDTH;
  localparam int unsigned Bytes  = DATA_BITWIDTH / 8;
  localparam int unsigned BeatW  = $clog2(BURST_COUNT + 1);
  localparam int unsigned CntMax = (READ_LATENCY > INIT_CYCLES) ? READ_LATENCY : INIT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StReadWait, StReadBurst, StWriteBurst, StInit} state_e;

`ifdef BURST_RAM_RESPONDER_INIT_DELAY_EN
  localparam state_e ResetState = StInit;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e                    r_state;
  state_e                    w_state_next;
  logic [DEPTH_BITWIDTH-1:0] r_addr;
  logic [DEPTH_BITWIDTH-1:0] w_beat_addr;
  logic [DEPTH_BITWIDTH-1:0] w_wr_addr;
  logic [BeatW-1:0]          r_beat;
  logic [CntW-1:0]           r_cnt;
  logic [DATA_BITWIDTH-1:0]  r_rd_data;
  logic [DATA_BITWIDTH-1:0]  r_mem [Words];
  logic                      w_wr_en;
  logic                      w_rd_load;

  // Beat address wraps naturally at the address width.
  assign w_beat_addr   = r_addr + DEPTH_BITWIDTH'(r_beat);
  assign br.br_rd_data = r_rd_data;

  // State register with synchronous reset; a reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ResetState;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:       if (br.br_cmd_en) w_state_next = br.br_cmd ? StWriteBurst : StReadWait;
      StReadWait:   if (r_cnt == CntW'(READ_LATENCY - 2)) w_state_next = StReadBurst;
      StReadBurst:  if (r_beat == BeatW'(BURST_COUNT)) w_state_next = StIdle;
      StWriteBurst: if (r_beat == BeatW'(BURST_COUNT - 1)) w_state_next = StIdle;
      StInit:       if (r_cnt == CntW'(INIT_CYCLES - 1)) w_state_next = StIdle;
      default:      w_state_next = StIdle;
    endcase
  end

  // Outputs and datapath strobes decoded from state.
  always_comb begin
    br.br_busy          = (r_state != StIdle);
    br.br_rd_data_valid = (r_state == StReadBurst);
    w_wr_en             = 1'b0;
    w_wr_addr           = w_beat_addr;
    w_rd_load           = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Beat 0 of a write lands in the accept cycle itself.
        if (br.br_cmd_en && br.br_cmd && !rst) begin
          w_wr_en   = 1'b1;
          w_wr_addr = br.br_addr;
        end
      end
      StWriteBurst: w_wr_en   = !rst;
      StReadWait:   w_rd_load = (r_cnt == CntW'(READ_LATENCY - 2));
      StReadBurst:  w_rd_load = (r_beat != BeatW'(BURST_COUNT));
      default:      ;
    endcase
  end

  // Burst bookkeeping: latched address, beat index, latency/init counter, read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_rd_load) begin
        r_rd_data <= r_mem[w_beat_addr];
        r_beat    <= r_beat + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (br.br_cmd_en) begin
            r_addr <= br.br_addr;
            r_cnt  <= '0;
            // Write beat 0 is already done at accept, so the burst continues at beat 1.
            r_beat <= br.br_cmd ? BeatW'(1) : '0;
          end
        end
        StReadWait:   r_cnt  <= r_cnt + 1'b1;
        StWriteBurst: r_beat <= r_beat + 1'b1;
        StInit:       r_cnt  <= r_cnt + 1'b1;
        default:      ;
      endcase
    end
  end

  // Byte-masked write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < int'(Bytes); b++) begin
        if (!br.br_data_mask[b]) begin
          r_mem[w_wr_addr][b*8 +: 8] <= br.br_wr_data[b*8 +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_burst_ram_responder.sv
// Self-checking bench for burst_ram_responder: directed steps plus random bursts,
// compared against an array model of the RAM and the burst timing rules.
module tb_burst_ram_responder;
  localparam int unsigned DepthW = 4;
  localparam int unsigned DataW  = 64;
  localparam int unsigned BurstN = 4;
  localparam int unsigned RdLat  = 4;
  localparam int unsigned InitN  = 8;
  localparam int unsigned NWords = 16;

`ifdef BURST_RAM_RESPONDER_INIT_DELAY_EN
  localparam int unsigned ExpInit    = InitN;
  localparam logic        ExpRstBusy = 1'b1;
`else
  localparam int unsigned ExpInit    = 0;
  localparam logic        ExpRstBusy = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  burst_ram_responder_if #(.DEPTH_BITWIDTH(DepthW), .DATA_BITWIDTH(DataW)) bif ();

  burst_ram_responder #(
    .DEPTH_BITWIDTH(DepthW),
    .DATA_BITWIDTH (DataW),
    .BURST_COUNT   (BurstN),
    .READ_LATENCY  (RdLat),
    .INIT_CYCLES   (InitN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .br (bif)
  );

  always #5 clk = ~clk;

  logic [63:0] model [NWords];
  logic [63:0] wq [BurstN];
  logic [7:0]  mq [BurstN];
  logic [63:0] got [BurstN];
  int total = 0;
  int bad   = 0;
  int n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bif.br_cmd_en = 1'b0;
    repeat (cycles) tick();
  endtask

  task automatic rand_words(input bit rand_mask);
    for (int k = 0; k < int'(BurstN); k++) begin
      wq[k] = {$urandom, $urandom};
      mq[k] = rand_mask ? 8'($urandom) : 8'h00;
    end
  endtask

  // Model: beat k writes unmasked bytes of wq[k] to (a+k) mod 16.
  task automatic model_write(input int a);
    int idx;
    for (int k = 0; k < int'(BurstN); k++) begin
      idx = (a + k) % int'(NWords);
      for (int b = 0; b < 8; b++) begin
        if (!mq[k][b]) model[idx][b*8 +: 8] = wq[k][b*8 +: 8];
      end
    end
  endtask

  // Call in a cycle where the DUT should be idle; returns in the cycle busy drops.
  task automatic do_write(input int a);
    check("wr_idle", 64'(bif.br_busy), 64'(0));
    bif.br_cmd_en    = 1'b1;
    bif.br_cmd       = 1'b1;
    bif.br_addr      = 4'(a);
    bif.br_wr_data   = wq[0];
    bif.br_data_mask = mq[0];
    for (int k = 1; k < int'(BurstN); k++) begin
      tick();
      bif.br_cmd_en    = 1'b0;
      bif.br_cmd       = 1'($urandom);
      bif.br_addr      = 4'($urandom);
      bif.br_wr_data   = wq[k];
      bif.br_data_mask = mq[k];
      check("wr_busy", 64'(bif.br_busy), 64'(1));
      check("wr_novalid", 64'(bif.br_rd_data_valid), 64'(0));
    end
    tick();
    check("wr_done", 64'(bif.br_busy), 64'(0));
    model_write(a);
  endtask

  // Read burst at a; pulse drives ignored write commands during T+1..T+3.
  task automatic do_read(input int a, input bit pulse);
    bit exp_v;
    int idx;
    check("rd_idle", 64'(bif.br_busy), 64'(0));
    bif.br_cmd_en = 1'b1;
    bif.br_cmd    = 1'b0;
    bif.br_addr   = 4'(a);
    for (int c = 1; c <= int'(RdLat + BurstN); c++) begin
      tick();
      bif.br_cmd_en    = pulse && (c <= 3);
      bif.br_cmd       = 1'b1;
      bif.br_addr      = 4'($urandom);
      bif.br_wr_data   = {$urandom, $urandom};
      bif.br_data_mask = 8'h00;
      exp_v = (c >= int'(RdLat)) && (c < int'(RdLat + BurstN));
      check("rd_valid", 64'(bif.br_rd_data_valid), 64'(exp_v));
      check("rd_busy", 64'(bif.br_busy), 64'(c < int'(RdLat + BurstN)));
      if (exp_v) begin
        idx = (a + c - int'(RdLat)) % int'(NWords);
        got[c - int'(RdLat)] = bif.br_rd_data;
        check("rd_data", bif.br_rd_data, model[idx]);
      end else if (c == int'(RdLat + BurstN)) begin
        idx = (a + int'(BurstN) - 1) % int'(NWords);
        check("rd_hold", bif.br_rd_data, model[idx]);
      end
    end
    bif.br_cmd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bif.br_cmd       = 1'b0;
    bif.br_cmd_en    = 1'b0;
    bif.br_addr      = '0;
    bif.br_wr_data   = '0;
    bif.br_data_mask = '0;

    // Reset with a write command already pending; it must wait for reset/init.
    rand_words(1'b0);
    bif.br_cmd_en    = 1'b1;
    bif.br_cmd       = 1'b1;
    bif.br_addr      = 4'd0;
    bif.br_wr_data   = wq[0];
    bif.br_data_mask = mq[0];
    repeat (3) tick();
    check("rst_valid", 64'(bif.br_rd_data_valid), 64'(0));
    check("rst_data", bif.br_rd_data, 64'(0));
    check("rst_busy", 64'(bif.br_busy), 64'(ExpRstBusy));
    rst = 1'b0;
    n = 0;
    while (bif.br_busy && n < 50) begin
      tick();
      n++;
    end
    check("init_len", 64'(n), 64'(ExpInit));

    // Fill the whole RAM.
    do_write(0);
    for (int base = 4; base < 16; base += 4) begin
      rand_words(1'b0);
      do_write(base);
    end

    // Known-pattern write/read round trip.
    wq[0] = 64'h1111_1111_1111_1111;
    wq[1] = 64'h2222_2222_2222_2222;
    wq[2] = 64'h3333_3333_3333_3333;
    wq[3] = 64'h4444_4444_4444_4444;
    for (int k = 0; k < 4; k++) mq[k] = 8'h00;
    do_write(2);
    do_read(2, 1'b0);
    check("pat_beat0", got[0], 64'h1111_1111_1111_1111);
    check("pat_beat3", got[3], 64'h4444_4444_4444_4444);

    // Fresh contents everywhere, then a read that wraps past the top.
    for (int base = 0; base < 16; base += 4) begin
      rand_words(1'b0);
      do_write(base);
    end
    do_read(14, 1'b0);

    // Byte mask: only the upper four bytes of beat 1 get written.
    for (int k = 0; k < 4; k++) begin
      wq[k] = 64'h0;
      mq[k] = 8'h00;
    end
    do_write(5);
    wq[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    mq[0] = 8'hFF;
    mq[1] = 8'h0F;
    mq[2] = 8'hFF;
    mq[3] = 8'hFF;
    do_write(4);
    do_read(4, 1'b0);
    check("mask_beat1", got[1], 64'hFFFF_FFFF_0000_0000);

    // Commands during a read are ignored; the next one is accepted right at T+8.
    do_read(9, 1'b1);
    do_read(0, 1'b0);

    // Random mix with random masks and gaps.
    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        rand_words(1'b1);
        do_write($urandom_range(0, 15));
      end else begin
        do_read($urandom_range(0, 15), 1'($urandom));
      end
    end

    // Reset during beat 2 of a read.
    idle(1);
    check("rrst_idle", 64'(bif.br_busy), 64'(0));
    bif.br_cmd_en = 1'b1;
    bif.br_cmd    = 1'b0;
    bif.br_addr   = 4'd6;
    for (int c = 1; c <= int'(RdLat) + 2; c++) begin
      tick();
      bif.br_cmd_en = 1'b0;
    end
    check("rrst_pre_valid", 64'(bif.br_rd_data_valid), 64'(1));
    check("rrst_pre_data", bif.br_rd_data, model[8]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rrst_valid", 64'(bif.br_rd_data_valid), 64'(0));
    check("rrst_data", bif.br_rd_data, 64'(0));
    check("rrst_busy", 64'(bif.br_busy), 64'(ExpRstBusy));
    for (int c = 0; c < 12; c++) begin
      tick();
      check("rrst_no_beat", 64'(bif.br_rd_data_valid), 64'(0));
    end
    check("rrst_ready", 64'(bif.br_busy), 64'(0));

    // Memory survives reset.
    for (int base = 0; base < 16; base += 4) do_read(base, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
